// File: rtl/jtdd_pkg.sv
// Shared types and constants for the JTDD graphics ROM request path.
// JTDD_ROMRQ_CACHE2_EN selects a two-entry cache; default is one entry.
package jtdd_pkg;

  localparam int SDRAM_AW = 22;

`ifdef JTDD_ROMRQ_CACHE2_EN
  localparam int ROMRQ_ENTRIES = 2;
`else
  localparam int ROMRQ_ENTRIES = 1;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } romrq_st_e;

endpackage

// File: rtl/jtdd_romrq_cache.sv
// Tag store for the ROM request cache: combinational lookup, victim fill,
// and a 1-bit LRU pointer when two entries are present.
module jtdd_romrq_cache #(
  parameter int AW      = 17,
  parameter int ENTRIES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lookup,
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [15:0]   hit_data,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_tag,
  input  logic [15:0]   fill_data
);

  logic [ENTRIES-1:0] valid;
  logic [AW-1:0]      tag  [ENTRIES];
  logic [15:0]        data [ENTRIES];
  logic               hit_idx;
  logic               victim;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = 1'b0;
    hit_data = 16'h0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == addr) begin
        hit      = 1'b1;
        hit_idx  = 1'(i);
        hit_data = data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      for (int i = 0; i < ENTRIES; i++)
        if (victim == 1'(i)) valid[i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (victim == 1'(i)) begin
          tag[i]  <= fill_tag;
          data[i] <= fill_data;
        end
      end
    end
  end

  generate
    if (ENTRIES == 2) begin : g_lru
      // lru names the entry that was not most recently hit or filled
      logic lru;
      always_ff @(posedge clk) begin
        if (rst)                lru <= 1'b0;
        else if (fill_en)       lru <= ~victim;
        else if (lookup && hit) lru <= ~hit_idx;
      end
      assign victim = lru;
    end else begin : g_one
      logic unused_lookup;
      assign unused_lookup = ^{lookup, hit_idx};
      assign victim = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/jtdd_gfx_romrq.sv
// Tile-layer ROM request front end: small cache plus SDRAM fetch FSM.
// Define JTDD_ROMRQ_CACHE2_EN for a two-entry LRU cache.
module jtdd_gfx_romrq
  import jtdd_pkg::*;
#(
  parameter int                  AW     = 17,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  output logic [15:0]         rom_data,
  output logic                rom_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [15:0]         sdram_din
);

  romrq_st_e     st, st_nx;
  logic [AW-1:0] fetch_addr;
  logic          hit;
  logic [15:0]   hit_data;
  logic          start, fill;

  jtdd_romrq_cache #(.AW(AW), .ENTRIES(ROMRQ_ENTRIES)) u_cache (
    .clk       (clk),
    .rst       (rst),
    .lookup    (cs),
    .addr      (addr),
    .hit       (hit),
    .hit_data  (hit_data),
    .fill_en   (fill),
    .fill_tag  (fetch_addr),
    .fill_data (sdram_din)
  );

  always_comb begin
    st_nx = st;
    start = 1'b0;
    fill  = 1'b0;
    case (st)
      IDLE:      if (cs && !hit) begin st_nx = WAIT_ACK; start = 1'b1; end
      WAIT_ACK:  if (sdram_ack) st_nx = WAIT_DATA;
      WAIT_DATA: if (data_rdy) begin st_nx = IDLE; fill = 1'b1; end
      default:   st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      fetch_addr <= '0;
      sdram_addr <= OFFSET;
      sdram_req  <= 1'b0;
      rom_ok     <= 1'b0;
      rom_data   <= 16'h0;
    end else begin
      st <= st_nx;
      if (start) begin
        fetch_addr <= addr;
        sdram_addr <= OFFSET + SDRAM_AW'(addr);
        sdram_req  <= 1'b1;
      end else if (st == WAIT_ACK && sdram_ack) begin
        sdram_req  <= 1'b0;
      end
      // forward the fill only if the layer still wants the fetched word
      if (fill && cs && addr == fetch_addr) begin
        rom_ok   <= 1'b1;
        rom_data <= sdram_din;
      end else if (cs && hit) begin
        rom_ok   <= 1'b1;
        rom_data <= hit_data;
      end else begin
        rom_ok   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtdd_gfx_romrq.sv
// Directed bench for jtdd_gfx_romrq; cache-size dependent checks follow
// JTDD_ROMRQ_CACHE2_EN.
module tb_jtdd_gfx_romrq;

  localparam int          AW   = 17;
  localparam logic [21:0] OFFS = 22'h3F0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic [AW-1:0] addr;
  logic [15:0]   rom_data;
  logic          rom_ok;
  logic [21:0]   sdram_addr;
  logic          sdram_req;
  logic          sdram_ack;
  logic          data_rdy;
  logic [15:0]   sdram_din;

  int checks = 0;
  int errors = 0;

  jtdd_gfx_romrq #(.AW(AW), .OFFSET(OFFS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .addr       (addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .sdram_din  (sdram_din)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; cs = 1'b0; addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = 16'h0;
    tick; tick;
    rst = 1'b0;
  endtask

  // FSM assumed in WAIT_ACK: ack next edge, one data-wait cycle, then data
  task automatic serve(input logic [15:0] d);
    sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
    tick;
    data_rdy = 1'b1; sdram_din = d; tick; data_rdy = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL reset_rom_ok got %b want 0", rom_ok); end
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", sdram_req); end
    checks++; if (rom_data !== 16'h0) begin errors++; $display("FAIL reset_rom_data got %h want 0000", rom_data); end
    checks++; if (sdram_addr !== OFFS) begin errors++; $display("FAIL reset_sdram_addr got %h want %h", sdram_addr, OFFS); end
  endtask

  task automatic test_miss_fill;
    cs = 1'b1; addr = 17'h00010;
    tick;
    checks++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL miss_req got %b want 1", sdram_req); end
    checks++; if (sdram_addr !== 22'h3F0010) begin errors++; $display("FAIL miss_sdram_addr got %h want 3f0010", sdram_addr); end
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL miss_rom_ok got %b want 0", rom_ok); end
    tick;
    checks++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL req_held got %b want 1", sdram_req); end
    sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL req_clear_on_ack got %b want 0", sdram_req); end
    tick; tick;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL wait_data_rom_ok got %b want 0", rom_ok); end
    data_rdy = 1'b1; sdram_din = 16'hA5A5; tick; data_rdy = 1'b0;
    checks++; if (rom_ok !== 1'b1) begin errors++; $display("FAIL fwd_rom_ok got %b want 1", rom_ok); end
    checks++; if (rom_data !== 16'hA5A5) begin errors++; $display("FAIL fwd_rom_data got %h want a5a5", rom_data); end
  endtask

  task automatic test_hit;
    sdram_din = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (rom_ok !== 1'b1 || rom_data !== 16'hA5A5) begin errors++; $display("FAIL hit_%0d got ok=%b data=%h want ok=1 data=a5a5", i, rom_ok, rom_data); end
      checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL hit_no_req_%0d got %b want 0", i, sdram_req); end
    end
    cs = 1'b0; tick;
    checks++; if (rom_ok !== 1'b0 || rom_data !== 16'hA5A5) begin errors++; $display("FAIL cs_low got ok=%b data=%h want ok=0 data=a5a5", rom_ok, rom_data); end
    cs = 1'b1;
  endtask

  task automatic test_alternate;
    addr = 17'h00020; tick;
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h3F0020) begin errors++; $display("FAIL alt_fetch20 got req=%b addr=%h want req=1 addr=3f0020", sdram_req, sdram_addr); end
    serve(16'h2020);
    checks++; if (rom_ok !== 1'b1 || rom_data !== 16'h2020) begin errors++; $display("FAIL alt_fill20 got ok=%b data=%h want ok=1 data=2020", rom_ok, rom_data); end
`ifdef JTDD_ROMRQ_CACHE2_EN
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp_d;
      addr  = (i % 2 == 0) ? 17'h00010 : 17'h00020;
      exp_d = (i % 2 == 0) ? 16'hA5A5  : 16'h2020;
      tick;
      checks++; if (sdram_req !== 1'b0 || rom_ok !== 1'b1 || rom_data !== exp_d) begin errors++; $display("FAIL alt2_%0d got req=%b ok=%b data=%h want req=0 ok=1 data=%h", i, sdram_req, rom_ok, rom_data, exp_d); end
    end
`else
    addr = 17'h00010; tick;
    checks++; if (sdram_req !== 1'b1 || rom_ok !== 1'b0) begin errors++; $display("FAIL alt1_refetch10 got req=%b ok=%b want req=1 ok=0", sdram_req, rom_ok); end
    serve(16'hA5A5);
    checks++; if (rom_ok !== 1'b1 || rom_data !== 16'hA5A5) begin errors++; $display("FAIL alt1_fill10 got ok=%b data=%h want ok=1 data=a5a5", rom_ok, rom_data); end
    addr = 17'h00020; tick;
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h3F0020) begin errors++; $display("FAIL alt1_refetch20 got req=%b addr=%h want req=1 addr=3f0020", sdram_req, sdram_addr); end
    serve(16'h2020);
`endif
  endtask

  task automatic test_addr_change;
    apply_reset;
    cs = 1'b1; addr = 17'h00010; tick;
    sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
    addr = 17'h00030; tick;
    data_rdy = 1'b1; sdram_din = 16'hBEEF; tick; data_rdy = 1'b0;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL chg_no_fwd got %b want 0", rom_ok); end
    tick;
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h3F0030 || rom_ok !== 1'b0) begin errors++; $display("FAIL chg_fetch30 got req=%b addr=%h ok=%b want req=1 addr=3f0030 ok=0", sdram_req, sdram_addr, rom_ok); end
    serve(16'hC3C3);
    checks++; if (rom_ok !== 1'b1 || rom_data !== 16'hC3C3) begin errors++; $display("FAIL chg_fill30 got ok=%b data=%h want ok=1 data=c3c3", rom_ok, rom_data); end
    addr = 17'h00010; tick;
`ifdef JTDD_ROMRQ_CACHE2_EN
    checks++; if (sdram_req !== 1'b0 || rom_ok !== 1'b1 || rom_data !== 16'hBEEF) begin errors++; $display("FAIL chg_tag10 got req=%b ok=%b data=%h want req=0 ok=1 data=beef", sdram_req, rom_ok, rom_data); end
`else
    checks++; if (sdram_req !== 1'b1 || rom_ok !== 1'b0) begin errors++; $display("FAIL chg_evict10 got req=%b ok=%b want req=1 ok=0", sdram_req, rom_ok); end
`endif
  endtask

  task automatic test_wrap;
    apply_reset;
    cs = 1'b1; addr = 17'h1FFFF; tick;
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00FFFF) begin errors++; $display("FAIL wrap got req=%b addr=%h want req=1 addr=00ffff", sdram_req, sdram_addr); end
  endtask

  task automatic test_reset_mid_fetch;
    apply_reset;
    cs = 1'b1; addr = 17'h00040; tick;
    sdram_ack = 1'b1; tick; sdram_ack = 1'b0;
    cs = 1'b0; rst = 1'b1; tick; rst = 1'b0;
    checks++; if (sdram_req !== 1'b0 || rom_ok !== 1'b0 || sdram_addr !== OFFS) begin errors++; $display("FAIL rst_mid got req=%b ok=%b addr=%h want req=0 ok=0 addr=%h", sdram_req, rom_ok, sdram_addr, OFFS); end
    cs = 1'b1; data_rdy = 1'b1; sdram_din = 16'h1234; tick; data_rdy = 1'b0;
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL stray_rdy_ok got %b want 0", rom_ok); end
    tick;
    checks++; if (sdram_req !== 1'b1 || rom_ok !== 1'b0 || sdram_addr !== 22'h3F0040) begin errors++; $display("FAIL stray_cache_empty got req=%b ok=%b addr=%h want req=1 ok=0 addr=3f0040", sdram_req, rom_ok, sdram_addr); end
  endtask

  initial begin
    test_reset;
    test_miss_fill;
    test_hit;
    test_alternate;
    test_addr_change;
    test_wrap;
    test_reset_mid_fetch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtdd_gfx_romrq.md
JTDD_GFX_ROMRQ -- requirements
Module: jtdd_gfx_romrq

Interface
REQ-001 The module SHALL have parameter AW, default 17, meaning the width of the layer-side word address.
REQ-002 The module SHALL have parameter OFFSET, default 22'h0, meaning the SDRAM word base added to every layer address.
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the system clock; it is the only clock.
REQ-004 The module SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-005 The module SHALL have port cs, input, 1 bit, meaning the layer is requesting data at addr.
REQ-006 The module SHALL have port addr, input, AW bits, meaning the layer ROM word address (the tile layer's rom_addr).
REQ-007 The module SHALL have port rom_data, output, 16 bits, meaning the word returned to the layer.
REQ-008 The module SHALL have port rom_ok, output, 1 bit, meaning rom_data matches the current addr.
REQ-009 The module SHALL have port sdram_addr, output, 22 bits, meaning the SDRAM word address, equal to OFFSET+addr.
REQ-010 The module SHALL have port sdram_req, output, 1 bit, meaning an SDRAM read is requested.
REQ-011 The module SHALL have port sdram_ack, input, 1 bit, meaning the SDRAM controller has accepted the request.
REQ-012 The module SHALL have port data_rdy, input, 1 bit, meaning sdram_din is valid for one cycle.
REQ-013 The module SHALL have port sdram_din, input, 16 bits, meaning SDRAM read data.

Function
REQ-014 The module SHALL hold cache entries, each with a valid bit, an AW-bit tag and a 16-bit data word.
REQ-015 Hit: when cs=1 and addr equals a valid tag, the module SHALL register rom_ok=1 and rom_data=that entry's data on the next clock edge.
REQ-016 Miss or cs=0: the module SHALL register rom_ok=0; rom_data SHALL keep its last value.
REQ-017 The FSM SHALL have states IDLE, WAIT_ACK and WAIT_DATA.
REQ-018 IDLE->WAIT_ACK on cs=1 and a miss: the module SHALL latch addr as fetch_addr, drive sdram_addr=OFFSET+fetch_addr, and set sdram_req=1.
REQ-019 WAIT_ACK->WAIT_DATA on sdram_ack=1, with sdram_req cleared on the same edge.
REQ-020 WAIT_DATA->IDLE on data_rdy=1: the module SHALL write sdram_din and fetch_addr into the victim entry and set its valid bit.
REQ-021 On the data_rdy edge, if cs=1 and addr==fetch_addr, the module SHALL assert rom_ok=1 with rom_data=sdram_din on that same edge (fill-forward).
REQ-022 Miss-to-rom_ok latency SHALL be 1 cycle (IDLE) + ack wait + data wait, plus 0 cycles for forwarding.
REQ-023 An addr change during WAIT_ACK or WAIT_DATA SHALL NOT abort the fetch; the fill completes under fetch_addr, and the new addr is evaluated in IDLE on the following cycle.
REQ-024 If cs drops mid-fetch, the fetch SHALL complete and fill the cache, and rom_ok SHALL stay 0.
REQ-025 sdram_addr arithmetic SHALL be 22-bit, zero-extending addr and wrapping modulo 2^22.
REQ-026 rom_ok SHALL never be 1 in any cycle where the registered addr differs from the tag supplying rom_data.

Reset
REQ-027 On rst=1, the module SHALL clear all valid bits, set rom_ok=0, sdram_req=0, rom_data=0, sdram_addr=OFFSET, and set the FSM to IDLE.
REQ-028 rst asserted mid-fetch SHALL abandon the fetch, and a data_rdy arriving after reset SHALL be ignored.

Configuration
REQ-029 With macro JTDD_ROMRQ_CACHE2_EN defined, the module SHALL hold two entries, the victim being the entry not most recently hit or filled (1-bit LRU).
REQ-030 Without JTDD_ROMRQ_CACHE2_EN, the module SHALL hold one entry that is always the victim, and all other behaviour SHALL be identical.

Structure
REQ-031 The FSM state encoding typedef and the SDRAM address width constant (22) SHALL reside in shared package jtdd_pkg.
REQ-032 The tag-compare and storage array SHALL be a sub-module named jtdd_romrq_cache; the FSM and port logic SHALL stay in the top module.

Verification
REQ-033 Reset then cs=1, addr=17'h00010, ack after 2 cycles, data_rdy 3 cycles later with 16'hA5A5 -> sdram_addr=OFFSET+0x10, rom_ok=1, rom_data=A5A5 on the data_rdy edge.
REQ-034 Re-present addr=0x00010 after the fill -> rom_ok=1 on the next edge, and no sdram_req.
REQ-035 With JTDD_ROMRQ_CACHE2_EN, alternate addr 0x10 and 0x20 after both are filled -> no further sdram_req.
REQ-036 Without JTDD_ROMRQ_CACHE2_EN, alternate addr 0x10 and 0x20 -> one fetch per change.
REQ-037 Change addr from 0x10 to 0x30 during WAIT_DATA -> fill tagged 0x10, rom_ok stays 0, then a new fetch for 0x30 begins.
REQ-038 Assert rst in WAIT_DATA, then a stray data_rdy with 16'h1234 -> rom_ok=0, cache stays empty, and the FSM stays in IDLE.
